// File: rtl/dcache_param_if.sv
// rtl/dcache_param_if.sv - datapath and memory-side signal bundle for dcache_param
interface dcache_param_if;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [31:0] dmemload;
   logic        dhit;
   logic        halt;
   logic        flushed;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;

   // cache side
   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
      output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
   );

   // datapath plus memory controller side
   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
      input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
   );
endinterface

// File: rtl/dcache_param.sv
// rtl/dcache_param.sv - parametrised write-back write-allocate set-associative L1 data cache
module dcache_param #(
   parameter int          SETS     = 8,
   parameter int          WAYS     = 2,
   parameter int          WORDS    = 2,
   parameter logic [31:0] HIT_ADDR = 32'h3100
) (
   input  logic          CLK,
   input  logic          nRST,
   dcache_param_if.slave bus
);
   localparam int OB  = $clog2(WORDS);
   localparam int IB  = $clog2(SETS);
   localparam int TB  = 30 - OB - IB;
   localparam int WIX = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WB, S_ALLOC, S_FLUSH, S_COUNT, S_DONE} state_t;

   // line storage; ages double as the true-LRU order within a set
   logic            valid_q [SETS][WAYS];
   logic            dirty_q [SETS][WAYS];
   logic [TB-1:0]   tag_q   [SETS][WAYS];
   logic [WIX-1:0]  age_q   [SETS][WAYS];
   logic [31:0]     data_q  [SETS][WAYS][WORDS];

   state_t          state_q, state_d;
   logic [OB-1:0]   beat_q, beat_d;
   logic [WIX-1:0]  victim_q, victim_d;
   logic [IB-1:0]   ridx_q, ridx_d;
   logic [TB-1:0]   rtag_q, rtag_d;
   logic [IB-1:0]   fset_q, fset_d;
   logic [WIX-1:0]  fway_q, fway_d;
   logic [31:0]     hits_q, hits_d;
   logic            refill_q, refill_d;

   logic [TB-1:0]   req_tag;
   logic [IB-1:0]   req_idx;
   logic [OB-1:0]   req_off;
   logic            req;
   logic            hit_any;
   logic [WIX-1:0]  hit_way;
   logic            inv_found;
   logic [WIX-1:0]  vict_sel;

   logic            touch_en;
   logic [IB-1:0]   touch_set;
   logic [WIX-1:0]  touch_way;
   logic            wr_hit;
   logic            fill_we;
   logic            fill_done;
   logic            clean_en;
   logic [IB-1:0]   clean_set;
   logic [WIX-1:0]  clean_way;
   logic            line_adv;

   logic            dhit_c, dren_c, dwen_c, flushed_c;
   logic [31:0]     daddr_c, dstore_c;

   assign req_tag = bus.dmemaddr[31 -: TB];
   assign req_idx = bus.dmemaddr[2 + OB +: IB];
   assign req_off = bus.dmemaddr[2 +: OB];
   assign req     = bus.dmemREN | bus.dmemWEN;

   assign bus.dhit     = dhit_c;
   assign bus.dmemload = data_q[req_idx][hit_way][req_off];
   assign bus.flushed  = flushed_c;
   assign bus.dREN     = dren_c;
   assign bus.dWEN     = dwen_c;
   assign bus.daddr    = daddr_c;
   assign bus.dstore   = dstore_c;

   // tag compare across all ways of the addressed set
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit_any = 1'b1;
            hit_way = WIX'(w);
         end
      end
   end

   // victim choice: lowest invalid way first, otherwise the oldest way
   always_comb begin
      inv_found = 1'b0;
      vict_sel  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            vict_sel  = WIX'(w);
         end
      end
      if (!inv_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[req_idx][w] == WIX'(WAYS - 1)) vict_sel = WIX'(w);
         end
      end
   end

   // next-state, bus outputs and array update strobes
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      victim_d  = victim_q;
      ridx_d    = ridx_q;
      rtag_d    = rtag_q;
      fset_d    = fset_q;
      fway_d    = fway_q;
      hits_d    = hits_q;
      refill_d  = refill_q;
      dhit_c    = 1'b0;
      dren_c    = 1'b0;
      dwen_c    = 1'b0;
      flushed_c = 1'b0;
      daddr_c   = '0;
      dstore_c  = '0;
      touch_en  = 1'b0;
      touch_set = req_idx;
      touch_way = hit_way;
      wr_hit    = 1'b0;
      fill_we   = 1'b0;
      fill_done = 1'b0;
      clean_en  = 1'b0;
      clean_set = ridx_q;
      clean_way = victim_q;
      line_adv  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.halt) begin
               state_d = S_FLUSH;
               fset_d  = '0;
               fway_d  = '0;
               beat_d  = '0;
            end else if (req) begin
               if (hit_any) begin
                  dhit_c   = 1'b1;
                  touch_en = 1'b1;
                  wr_hit   = bus.dmemWEN;
                  refill_d = 1'b0;
                  // the retry after a fill is not a genuine hit
                  if (!refill_q) hits_d = hits_q + 32'd1;
               end else begin
                  victim_d = vict_sel;
                  ridx_d   = req_idx;
                  rtag_d   = req_tag;
                  beat_d   = '0;
                  refill_d = 1'b1;
                  state_d  = (valid_q[req_idx][vict_sel] && dirty_q[req_idx][vict_sel]) ? S_WB : S_ALLOC;
               end
            end
         end
         S_WB: begin
            dwen_c   = 1'b1;
            daddr_c  = {tag_q[ridx_q][victim_q], ridx_q, beat_q, 2'b00};
            dstore_c = data_q[ridx_q][victim_q][beat_q];
            if (!bus.dwait) begin
               if (beat_q == OB'(WORDS - 1)) begin
                  beat_d   = '0;
                  clean_en = 1'b1;
                  state_d  = S_ALLOC;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_ALLOC: begin
            dren_c  = 1'b1;
            daddr_c = {rtag_q, ridx_q, beat_q, 2'b00};
            if (!bus.dwait) begin
               fill_we = 1'b1;
               if (beat_q == OB'(WORDS - 1)) begin
                  fill_done = 1'b1;
                  touch_en  = 1'b1;
                  touch_set = ridx_q;
                  touch_way = victim_q;
                  beat_d    = '0;
                  state_d   = S_IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
               dwen_c   = 1'b1;
               daddr_c  = {tag_q[fset_q][fway_q], fset_q, beat_q, 2'b00};
               dstore_c = data_q[fset_q][fway_q][beat_q];
               if (!bus.dwait) begin
                  if (beat_q == OB'(WORDS - 1)) begin
                     beat_d    = '0;
                     clean_en  = 1'b1;
                     clean_set = fset_q;
                     clean_way = fway_q;
                     line_adv  = 1'b1;
                  end else begin
                     beat_d = beat_q + 1'b1;
                  end
               end
            end else begin
               line_adv = 1'b1;
            end
            if (line_adv) begin
               if (fway_q == WIX'(WAYS - 1)) begin
                  fway_d = '0;
                  if (fset_q == IB'(SETS - 1)) state_d = S_COUNT;
                  else                         fset_d  = fset_q + 1'b1;
               end else begin
                  fway_d = fway_q + 1'b1;
               end
            end
         end
         S_COUNT: begin
            dwen_c   = 1'b1;
            daddr_c  = HIT_ADDR;
            dstore_c = hits_q;
            if (!bus.dwait) state_d = S_DONE;
         end
         S_DONE: begin
            flushed_c = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // control state registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= S_IDLE;
         beat_q   <= '0;
         victim_q <= '0;
         ridx_q   <= '0;
         rtag_q   <= '0;
         fset_q   <= '0;
         fway_q   <= '0;
         hits_q   <= '0;
         refill_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         victim_q <= victim_d;
         ridx_q   <= ridx_d;
         rtag_q   <= rtag_d;
         fset_q   <= fset_d;
         fway_q   <= fway_d;
         hits_q   <= hits_d;
         refill_q <= refill_d;
      end
   end

   // line metadata and LRU ages; a line only turns valid once its fill completes
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               tag_q[s][w]   <= '0;
               age_q[s][w]   <= WIX'(w);
            end
         end
      end else begin
         if (wr_hit)   dirty_q[req_idx][hit_way]     <= 1'b1;
         if (clean_en) dirty_q[clean_set][clean_way] <= 1'b0;
         if (fill_done) begin
            valid_q[ridx_q][victim_q] <= 1'b1;
            dirty_q[ridx_q][victim_q] <= 1'b0;
            tag_q[ridx_q][victim_q]   <= rtag_q;
         end
         if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WIX'(w) == touch_way)
                  age_q[touch_set][w] <= '0;
               else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
                  age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
            end
         end
      end
   end

   // data words: write hits and fill beats
   always_ff @(posedge CLK) begin
      if (wr_hit)  data_q[req_idx][hit_way][req_off] <= bus.dmemstore;
      if (fill_we) data_q[ridx_q][victim_q][beat_q]  <= bus.dload;
   end
endmodule

// File: tb/tb_dcache_param.sv
// tb/tb_dcache_param.sv - directed self-checking bench for dcache_param
module tb_dcache_param;
   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic clk = 1'b0;
   logic nrst_a = 1'b0;
   logic nrst_b = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   wait_a = 0;
   int   wait_b = 0;
   int   cnt_a = 0;
   int   cnt_b = 0;

   logic [31:0] mem_a [logic [31:0]];
   logic [31:0] mem_b [logic [31:0]];
   txn_t        log_a [$];
   txn_t        log_b [$];

   dcache_param_if ifa ();
   dcache_param_if ifb ();

   dcache_param u_dut (.CLK(clk), .nRST(nrst_a), .bus(ifa));
   dcache_param #(.SETS(4), .WAYS(4), .WORDS(4), .HIT_ADDR(32'h3100)) u_dut4 (.CLK(clk), .nRST(nrst_b), .bus(ifb));

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_a(input logic [31:0] a);
      return mem_a.exists(a) ? mem_a[a] : a + 32'h60;
   endfunction

   function automatic logic [31:0] rd_b(input logic [31:0] a);
      return mem_b.exists(a) ? mem_b[a] : a + 32'h60;
   endfunction

   function automatic txn_t log_at(input int sel, input int i);
      txn_t t;
      t = '{wr: 1'bx, addr: 32'hx, data: 32'hx};
      if (sel == 0 && i < log_a.size()) t = log_a[i];
      if (sel == 1 && i < log_b.size()) t = log_b[i];
      return t;
   endfunction

   // memory controller model for the default cache: wait_a busy cycles per beat
   always @(negedge clk) begin
      if (ifa.dREN || ifa.dWEN) begin
         if (cnt_a < wait_a) begin
            ifa.dwait = 1'b1;
            cnt_a++;
         end else begin
            ifa.dwait = 1'b0;
            cnt_a = 0;
            if (ifa.dWEN) begin
               mem_a[ifa.daddr] = ifa.dstore;
               log_a.push_back('{wr: 1'b1, addr: ifa.daddr, data: ifa.dstore});
            end else begin
               ifa.dload = rd_a(ifa.daddr);
               log_a.push_back('{wr: 1'b0, addr: ifa.daddr, data: ifa.dload});
            end
         end
      end else begin
         ifa.dwait = 1'b1;
         cnt_a = 0;
      end
   end

   // memory controller model for the 4x4x4 cache
   always @(negedge clk) begin
      if (ifb.dREN || ifb.dWEN) begin
         if (cnt_b < wait_b) begin
            ifb.dwait = 1'b1;
            cnt_b++;
         end else begin
            ifb.dwait = 1'b0;
            cnt_b = 0;
            if (ifb.dWEN) begin
               mem_b[ifb.daddr] = ifb.dstore;
               log_b.push_back('{wr: 1'b1, addr: ifb.daddr, data: ifb.dstore});
            end else begin
               ifb.dload = rd_b(ifb.daddr);
               log_b.push_back('{wr: 1'b0, addr: ifb.daddr, data: ifb.dload});
            end
         end
      end else begin
         ifb.dwait = 1'b1;
         cnt_b = 0;
      end
   end

   task automatic drive(input int sel, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] d);
      if (sel == 0) begin
         ifa.dmemREN = ren; ifa.dmemWEN = wen; ifa.dmemaddr = addr; ifa.dmemstore = d;
      end else begin
         ifb.dmemREN = ren; ifb.dmemWEN = wen; ifb.dmemaddr = addr; ifb.dmemstore = d;
      end
   endtask

   // one datapath access; cycles counts the cycles spent before the dhit cycle
   task automatic access(input int sel, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int cycles, output logic got);
      @(posedge clk); #1;
      drive(sel, !wr, wr, addr, wdata);
      got = 1'b0;
      cycles = 0;
      rdata = '0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if ((sel == 0) ? ifa.dhit : ifb.dhit) begin
            got = 1'b1;
            rdata = (sel == 0) ? ifa.dmemload : ifb.dmemload;
         end else begin
            cycles++;
            @(posedge clk);
         end
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, addr, 32'h0);
   endtask

   task automatic reset_a();
      @(posedge clk); #2;
      nrst_a = 1'b0;
      repeat (2) @(posedge clk);
      #1 nrst_a = 1'b1;
      log_a.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({ifa.dhit, ifa.flushed, ifa.dREN, ifa.dWEN} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000", {ifa.dhit, ifa.flushed, ifa.dREN, ifa.dWEN});
      end
      checks++;
      if ({ifa.daddr, ifa.dstore} !== 64'h0) begin
         errors++; $display("FAIL reset_bus: daddr %h dstore %h expected 0", ifa.daddr, ifa.dstore);
      end
      #1 nrst_a = 1'b1; nrst_b = 1'b1;
      @(negedge clk);
      checks++;
      if ({ifb.dhit, ifb.flushed, ifb.dREN, ifb.dWEN} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl4: got %b expected 0000", {ifb.dhit, ifb.flushed, ifb.dREN, ifb.dWEN});
      end
   endtask

   task automatic test_cold_read();
      logic [31:0] rd; int cyc; logic got;
      txn_t exp [2];
      exp[0] = '{wr: 1'b0, addr: 32'h40, data: 32'hA0};
      exp[1] = '{wr: 1'b0, addr: 32'h44, data: 32'hA4};
      wait_a = 2;
      log_a.delete();
      access(0, 1'b0, 32'h40, 32'h0, rd, cyc, got);
      checks++;
      if (!got || rd !== 32'hA0) begin errors++; $display("FAIL cold_rd_data: got %h (hit %b) expected 000000a0", rd, got); end
      checks++;
      if (cyc != 7) begin errors++; $display("FAIL cold_rd_latency: got %0d expected 7", cyc); end
      checks++;
      if (log_a.size() != 2) begin errors++; $display("FAIL cold_rd_beats: got %0d expected 2", log_a.size()); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (log_at(0, i) !== exp[i]) begin errors++; $display("FAIL cold_rd_txn[%0d]: got %h expected %h", i, log_at(0, i), exp[i]); end
      end
      access(0, 1'b0, 32'h44, 32'h0, rd, cyc, got);
      checks++;
      if (!got || rd !== 32'hA4 || cyc != 0) begin
         errors++; $display("FAIL warm_rd: got %h after %0d cycles expected 000000a4 after 0", rd, cyc);
      end
   endtask

   task automatic test_writeback();
      logic [31:0] rd; int cyc; logic got;
      txn_t exp [4];
      exp[0] = '{wr: 1'b1, addr: 32'h40, data: 32'hDEAD};
      exp[1] = '{wr: 1'b1, addr: 32'h44, data: 32'hA4};
      exp[2] = '{wr: 1'b0, addr: 32'hC0, data: 32'h120};
      exp[3] = '{wr: 1'b0, addr: 32'hC4, data: 32'h124};
      wait_a = 0;
      access(0, 1'b1, 32'h40, 32'hDEAD, rd, cyc, got);
      checks++;
      if (!got || cyc != 0) begin errors++; $display("FAIL wr_hit: got %0d cycles (hit %b) expected 0", cyc, got); end
      access(0, 1'b0, 32'h80, 32'h0, rd, cyc, got);
      checks++;
      if (rd !== 32'hE0 || cyc != 3) begin errors++; $display("FAIL fill_80: got %h after %0d expected 000000e0 after 3", rd, cyc); end
      log_a.delete();
      access(0, 1'b0, 32'hC0, 32'h0, rd, cyc, got);
      checks++;
      if (rd !== 32'h120 || cyc != 5) begin errors++; $display("FAIL evict_C0: got %h after %0d expected 00000120 after 5", rd, cyc); end
      checks++;
      if (log_a.size() != 4) begin errors++; $display("FAIL wb_count: got %0d expected 4", log_a.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_at(0, i) !== exp[i]) begin errors++; $display("FAIL wb_txn[%0d]: got %h expected %h", i, log_at(0, i), exp[i]); end
      end
   endtask

   task automatic test_lru();
      logic [31:0] rd; int cyc; logic got;
      reset_a();
      wait_a = 0;
      access(0, 1'b0, 32'h00, 32'h0, rd, cyc, got);
      access(0, 1'b0, 32'h80, 32'h0, rd, cyc, got);
      access(0, 1'b0, 32'h00, 32'h0, rd, cyc, got);
      checks++;
      if (rd !== 32'h60 || cyc != 0) begin errors++; $display("FAIL lru_hit0: got %h after %0d expected 00000060 after 0", rd, cyc); end
      log_a.delete();
      access(0, 1'b0, 32'h100, 32'h0, rd, cyc, got);
      checks++;
      if (log_a.size() != 2 || log_at(0, 0) !== '{wr: 1'b0, addr: 32'h100, data: 32'h160}) begin
         errors++; $display("FAIL lru_alloc: got %0d txns first %h expected 2 reads from 00000100", log_a.size(), log_at(0, 0));
      end
      access(0, 1'b0, 32'h00, 32'h0, rd, cyc, got);
      checks++;
      if (cyc != 0) begin errors++; $display("FAIL lru_keep0: got %0d cycles expected 0", cyc); end
      access(0, 1'b0, 32'h80, 32'h0, rd, cyc, got);
      checks++;
      if (cyc == 0) begin errors++; $display("FAIL lru_evict80: got %0d cycles expected a miss", cyc); end
   endtask

   task automatic test_4way();
      logic [31:0] rd; int cyc; logic got; logic [31:0] base;
      wait_b = 0;
      for (int t = 0; t < 5; t++) begin
         base = 32'(t) << 6;
         log_b.delete();
         access(1, 1'b0, base | 32'h8, 32'h0, rd, cyc, got);
         checks++;
         if (rd !== base + 32'h68 || cyc != 5) begin
            errors++; $display("FAIL w4_fill[%0d]: got %h after %0d expected %h after 5", t, rd, cyc, base + 32'h68);
         end
         checks++;
         if (log_b.size() != 4 || log_at(1, 0).addr !== base || log_at(1, 3).addr !== base + 32'hC) begin
            errors++; $display("FAIL w4_beats[%0d]: got %0d beats %h..%h expected 4 beats %h..%h",
                               t, log_b.size(), log_at(1, 0).addr, log_at(1, 3).addr, base, base + 32'hC);
         end
      end
      for (int t = 1; t < 5; t++) begin
         access(1, 1'b0, 32'(t) << 6, 32'h0, rd, cyc, got);
         checks++;
         if (!got || cyc != 0) begin errors++; $display("FAIL w4_resident[%0d]: got %0d cycles expected 0", t, cyc); end
      end
      access(1, 1'b0, 32'h0, 32'h0, rd, cyc, got);
      checks++;
      if (cyc != 5) begin errors++; $display("FAIL w4_evicted0: got %0d cycles expected 5", cyc); end
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] rd; int cyc; logic got;
      reset_a();
      wait_a = 2;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h200, 32'h0);
      for (int i = 0; i < 50 && log_a.size() == 0; i++) @(posedge clk);
      #2 nrst_a = 1'b0;
      #1;
      checks++;
      if (log_a.size() != 1 || ifa.dREN !== 1'b0) begin
         errors++; $display("FAIL abort_fill: got %0d beats dREN %b expected 1 beat dREN 0", log_a.size(), ifa.dREN);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      nrst_a = 1'b1;
      log_a.delete();
      access(0, 1'b0, 32'h200, 32'h0, rd, cyc, got);
      checks++;
      if (rd !== 32'h260 || cyc != 7 || log_a.size() != 2) begin
         errors++; $display("FAIL refill: got %h after %0d with %0d beats expected 00000260 after 7 with 2", rd, cyc, log_a.size());
      end
   endtask

   task automatic test_flush();
      logic [31:0] rd; int cyc; logic got;
      txn_t exp [5];
      exp[0] = '{wr: 1'b1, addr: 32'h40,   data: 32'h1111};
      exp[1] = '{wr: 1'b1, addr: 32'h44,   data: 32'hA4};
      exp[2] = '{wr: 1'b1, addr: 32'h1C8,  data: 32'h2222};
      exp[3] = '{wr: 1'b1, addr: 32'h1CC,  data: 32'h22C};
      exp[4] = '{wr: 1'b1, addr: 32'h3100, data: 32'h3};
      reset_a();
      wait_a = 1;
      access(0, 1'b0, 32'h40,  32'h0,    rd, cyc, got);
      access(0, 1'b1, 32'h40,  32'h1111, rd, cyc, got);
      access(0, 1'b0, 32'h1C8, 32'h0,    rd, cyc, got);
      access(0, 1'b1, 32'h1C8, 32'h2222, rd, cyc, got);
      access(0, 1'b0, 32'h44,  32'h0,    rd, cyc, got);
      checks++;
      if (rd !== 32'hA4 || cyc != 0) begin errors++; $display("FAIL pre_flush_hit: got %h after %0d expected 000000a4 after 0", rd, cyc); end
      log_a.delete();
      @(posedge clk); #1;
      ifa.halt = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge clk);
         if (ifa.flushed) got = 1'b1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL flush_done: flushed stayed %b expected 1", ifa.flushed); end
      checks++;
      if (log_a.size() != 5) begin errors++; $display("FAIL flush_count: got %0d txns expected 5", log_a.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (log_at(0, i) !== exp[i]) begin errors++; $display("FAIL flush_txn[%0d]: got %h expected %h", i, log_at(0, i), exp[i]); end
      end
      drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
      repeat (3) @(negedge clk);
      checks++;
      if ({ifa.flushed, ifa.dhit, ifa.dREN, ifa.dWEN} !== 4'b1000) begin
         errors++; $display("FAIL done_idle: got %b expected 1000", {ifa.flushed, ifa.dhit, ifa.dREN, ifa.dWEN});
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      ifa.halt = 1'b0;
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      ifa.halt = 1'b0; ifb.halt = 1'b0;
      ifa.dwait = 1'b1; ifb.dwait = 1'b1;
      ifa.dload = '0; ifb.dload = '0;
      test_reset();
      test_cold_read();
      test_writeback();
      test_lru();
      test_4way();
      test_reset_mid_fill();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
